srlatch_pd_sequencer: RTL

- Controls the SR-latch bang-bang phase detector in the ADPLL. It drives the latch S/R inputs from the reference and DCO edges, waits for the latch output to settle, then samples it through a synchronizer.
- Each measurement produces one registered early/late decision for the digital loop filter.
- Also tracks bang-bang dither to report lock.

---
 rtl/srlatch_pd_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/srlatch_pd_sequencer.sv
// Sequencer for the SR-latch bang-bang phase detector: drives S/R, samples Q,
// emits early/late decisions and tracks dither lock.
module srlatch_pd_sequencer #(
    parameter int PULSE_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int LOCK_COUNT  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ref_edge,
    input  logic dco_edge,
    input  logic latch_q,
    output logic latch_s,
    output logic latch_r,
    output logic pd_valid,
    output logic pd_lead,
    output logic pd_tie,
    output logic pd_err,
    output logic pd_timeout,
    output logic locked
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int CW = $clog2(PULSE_CYC + SYNC_STAGES + 2);

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SYNC_STAGES);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_COUNT);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ARM,
        S_PULSE,
        S_WAIT2,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic first_ref, first_ref_n;
    logic seen, seen_n;
    logic [SYNC_STAGES-1:0] sync;
    logic q_sync;
    logic opp;

    logic s_n, r_n, valid_n, lead_n, tie_n, err_n, to_n;

    logic [LW-1:0] lcnt;
    logic have_prev, prev_lead;
    logic lock_clr, lock_inc;

    assign q_sync = sync[SYNC_STAGES-1];
    assign opp    = first_ref ? dco_edge : ref_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], latch_q};
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        tcnt_n      = '0;
        first_ref_n = first_ref;
        seen_n      = seen;
        valid_n     = 1'b0;
        lead_n      = 1'b0;
        tie_n       = 1'b0;
        err_n       = 1'b0;
        to_n        = 1'b0;
        unique case (state)
            S_CLEAR: begin
                // Count only cycles where the reset drive is actually out.
                if (!latch_r) begin
                    cnt_n = '0;
                end else if (cnt == PULSE_LAST) begin
                    state_n = enable ? S_ARM : S_IDLE;
                end
            end
            S_IDLE: begin
                if (enable) state_n = S_ARM;
            end
            S_ARM: begin
                if (!enable) begin
                    state_n = S_IDLE;
                end else if (ref_edge && dco_edge) begin
                    state_n = S_CLEAR;
                    valid_n = 1'b1;
                    tie_n   = 1'b1;
                end else if (ref_edge || dco_edge) begin
                    state_n     = S_PULSE;
                    first_ref_n = ref_edge;
                    seen_n      = 1'b0;
                end
            end
            S_PULSE: begin
                seen_n = seen | opp;
                if (cnt == PULSE_LAST) begin
                    state_n = (seen | opp) ? S_SETTLE : S_WAIT2;
                end
            end
            S_WAIT2: begin
                tcnt_n = tcnt + TW'(1);
                if (opp) begin
                    state_n = S_SETTLE;
                end else if (tcnt == TO_LAST) begin
                    state_n = S_CLEAR;
                    to_n    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_n = S_SAMPLE;
                    valid_n = 1'b1;
                    lead_n  = q_sync;
                    err_n   = (q_sync != first_ref);
                end
            end
            S_SAMPLE: begin
                state_n = S_CLEAR;
            end
            default: begin
                state_n = S_CLEAR;
            end
        endcase
        if (state_n != state) begin
            cnt_n  = '0;
            tcnt_n = '0;
        end
    end

    // Drives follow the next state so they line up with the state register.
    assign s_n = (state_n == S_PULSE) && first_ref_n;
    assign r_n = (state_n == S_CLEAR) ||
                 ((state_n == S_PULSE) && !first_ref_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_CLEAR;
            cnt        <= '0;
            tcnt       <= '0;
            first_ref  <= 1'b0;
            seen       <= 1'b0;
            latch_s    <= 1'b0;
            latch_r    <= 1'b0;
            pd_valid   <= 1'b0;
            pd_lead    <= 1'b0;
            pd_tie     <= 1'b0;
            pd_err     <= 1'b0;
            pd_timeout <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            tcnt       <= tcnt_n;
            first_ref  <= first_ref_n;
            seen       <= seen_n;
            latch_s    <= s_n;
            latch_r    <= r_n;
            pd_valid   <= valid_n;
            pd_lead    <= lead_n;
            pd_tie     <= tie_n;
            pd_err     <= err_n;
            pd_timeout <= to_n;
        end
    end

    assign lock_clr = pd_timeout |
                      (pd_valid & (pd_err |
                      (!pd_tie & have_prev & (pd_lead == prev_lead))));
    assign lock_inc = pd_valid & !lock_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt      <= '0;
            have_prev <= 1'b0;
            prev_lead <= 1'b0;
            locked    <= 1'b0;
        end else begin
            if (lock_clr) begin
                lcnt <= '0;
            end else if (lock_inc && (lcnt != LOCK_MAX)) begin
                lcnt <= lcnt + LW'(1);
            end
            // Ties carry no direction, so they leave the reference untouched.
            if (pd_valid && !pd_tie) begin
                have_prev <= 1'b1;
                prev_lead <= pd_lead;
            end
            locked <= !lock_clr && (lcnt == LOCK_MAX);
        end
    end

endmodule
